// File: rtl/sim_ctrl_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sim_ctrl_mmio_pkg
//  Purpose  : Shared constants for the sim-control MMIO block: default window
//             base, register word offsets, CTRL command encodings and the
//             RUN/FINI state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sim_ctrl_mmio_pkg;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h4000_8000;

  // Word offsets, i.e. addr[7:2]
  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_MCYCLE   = 6'h01;
  localparam logic [5:0] OFF_MINSTRET = 6'h02;
  localparam logic [5:0] OFF_BR_PRED  = 6'h03;
  localparam logic [5:0] OFF_BR_MISP  = 6'h04;
  localparam logic [5:0] OFF_MTIME    = 6'h05;

  // CTRL command field, wdata[17:16]
  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUTC = 2'b01,
    CMD_FINI = 2'b10,
    CMD_CLR  = 2'b11
  } cmd_e;

  // Sticky finish state
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_FINI = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sim_ctrl_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module   : sim_ctrl_mmio_if
//  Purpose  : Bundles the CPU data-bus strobes and the outgoing UART byte
//             stream of the sim-control block.
//  Signals  : dbus_addr/we/wdata/re -> responder, dbus_rdata <- responder
//             tx_valid/tx_data <- responder, tx_ready -> responder
//  Modports : master = CPU + UART side, slave = sim_ctrl_mmio
//  Revision : 1.0  initial release
// ============================================================================
interface sim_ctrl_mmio_if;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [31:0] dbus_wdata;
  logic        dbus_re;
  logic [31:0] dbus_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output dbus_addr, dbus_we, dbus_wdata, dbus_re, tx_ready,
    input  dbus_rdata, tx_valid, tx_data
  );

  modport slave (
    input  dbus_addr, dbus_we, dbus_wdata, dbus_re, tx_ready,
    output dbus_rdata, tx_valid, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/sim_ctrl_mmio_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with full/empty flags. The head word comes
//             straight from the storage registers, so it is stable while not
//             popped. A push while full only lands if a pop happens in the
//             same cycle (pop frees the slot first).
//  Ports    : clk_i, rst_i        clock, sync active-high reset
//             push_i, data_i      write request and data
//             pop_i               read request (ignored when empty)
//             data_o              head word
//             empty_o, full_o     occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic              pop_eff, push_eff;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);
  assign data_o   = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (pop_eff) rd_q <= rd_q + AW'(1);
      if (push_eff) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sim_ctrl_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : sim_ctrl_mmio
//  Purpose  : Sim-control MMIO responder. Decodes putchar / finish / clear
//             stores, keeps performance counters readable by the CPU and
//             streams putchar bytes through a FIFO to a UART.
//  Ports    : clk_i, rst_i      clock, sync active-high reset
//             bus (slave)       data bus strobes + tx byte stream
//             retire_i          instruction retired this cycle
//             ctrl_tsfr_i       control transfer resolved this cycle
//             br_misp_i         that transfer was mispredicted
//             fini_o            sticky simulation-finished flag
//  Revision : 1.0  initial release
// ============================================================================
module sim_ctrl_mmio
  import sim_ctrl_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sim_ctrl_mmio_if.slave bus,
  input  logic           retire_i,
  input  logic           ctrl_tsfr_i,
  input  logic           br_misp_i,
  output logic           fini_o
);

  logic        hit, wr_ctrl, do_putc, do_fini, do_clr;
  logic [5:0]  off;
  cmd_e        cmd;
  logic        fifo_full, fifo_empty, pop;
  logic [0:0]  fin_state_q, fin_state_d;
  logic        ovf_q, ovf_d;
  logic [31:0] mtime_q, mcycle_q, minstret_q, brpred_q, brmisp_q;
  logic [31:0] mtime_d, mcycle_d, minstret_d, brpred_d, brmisp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        unused_bits;

  // ---------------- decode ----------------
  assign hit     = (bus.dbus_addr[31:8] == BASE_ADDR[31:8]);
  assign off     = bus.dbus_addr[7:2];
  assign cmd     = cmd_e'(bus.dbus_wdata[17:16]);
  assign wr_ctrl = bus.dbus_we && hit && (off == OFF_CTRL);
  assign do_putc = wr_ctrl && (cmd == CMD_PUTC);
  assign do_fini = wr_ctrl && (cmd == CMD_FINI);
  assign do_clr  = wr_ctrl && (cmd == CMD_CLR);

  assign unused_bits = ^{bus.dbus_addr[1:0], bus.dbus_wdata[31:18], bus.dbus_wdata[15:8]};

  // ---------------- putchar FIFO ----------------
  assign bus.tx_valid = !fifo_empty;
  assign pop          = bus.tx_valid && bus.tx_ready;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (do_putc),
    .data_i  (bus.dbus_wdata[7:0]),
    .pop_i   (pop),
    .data_o  (bus.tx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // A putchar into a full FIFO is only lost if no pop frees a slot this cycle.
  assign ovf_d = !do_clr && (ovf_q || (do_putc && fifo_full && !pop));

  // ---------------- RUN -> FINI ----------------
  always_comb begin
    fin_state_d = fin_state_q;
    case (fin_state_q)
      ST_RUN:  if (do_fini) fin_state_d = ST_FINI;
      default: fin_state_d = ST_FINI;
    endcase
  end

  assign fini_o = (fin_state_q == ST_FINI);

  // ---------------- counters ----------------
  // Clear overrides both the increment and the freeze.
  assign mtime_d    = mtime_q + 32'd1;
  assign mcycle_d   = do_clr ? '0 : (fini_o ? mcycle_q   : mcycle_q   + 32'd1);
  assign minstret_d = do_clr ? '0 : (fini_o ? minstret_q : minstret_q + {31'd0, retire_i});
  assign brpred_d   = do_clr ? '0 : (fini_o ? brpred_q   : brpred_q   + {31'd0, ctrl_tsfr_i});
  assign brmisp_d   = do_clr ? '0 : (fini_o ? brmisp_q   : brmisp_q   + {31'd0, ctrl_tsfr_i & br_misp_i});

  // ---------------- read mux (pre-update values) ----------------
  always_comb begin
    rdata_d = '0;
    if (bus.dbus_re && hit) begin
      case (off)
        OFF_CTRL:     rdata_d = {26'd0, ovf_q, fifo_full, fifo_empty, fini_o, 2'b00};
        OFF_MCYCLE:   rdata_d = mcycle_q;
        OFF_MINSTRET: rdata_d = minstret_q;
        OFF_BR_PRED:  rdata_d = brpred_q;
        OFF_BR_MISP:  rdata_d = brmisp_q;
        OFF_MTIME:    rdata_d = mtime_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  assign bus.dbus_rdata = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fin_state_q <= ST_RUN;
      ovf_q       <= 1'b0;
      mtime_q     <= '0;
      mcycle_q    <= '0;
      minstret_q  <= '0;
      brpred_q    <= '0;
      brmisp_q    <= '0;
      rdata_q     <= '0;
    end else begin
      fin_state_q <= fin_state_d;
      ovf_q       <= ovf_d;
      mtime_q     <= mtime_d;
      mcycle_q    <= mcycle_d;
      minstret_q  <= minstret_d;
      brpred_q    <= brpred_d;
      brmisp_q    <= brmisp_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule
`default_nettype wire
